board_controller: RTL and testbench

Game-board stage directly downstream of the coordinate input handler. Consumes each validated 4-bit (x, y) coordinate pulse, checks it against a BOARD_SIZE×BOARD_SIZE occupancy board, places the current player's piece (triangle or circle), and runs a sequential line-of-WIN_LEN scan around the new piece. Provides turn tracking, per-player move counts, win/draw status and a combinational cell read port for the display stage.

---
 rtl/board_controller.sv | 198 +++++++++++++++++++
 tb/tb_board_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/board_controller.sv
// Occupancy board with move validation, turn tracking and a sequential line-of-WIN_LEN scan per placed piece.
// Optional DRAW_DETECT_EN: a full board with no winner ends the game as a draw (winner=11).
module board_controller #(
  parameter int BOARD_SIZE = 10,
  parameter int WIN_LEN    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] x_in,
  input  logic [3:0] y_in,
  input  logic       coord_valid,
  input  logic [3:0] rd_x,
  input  logic [3:0] rd_y,
  output logic [1:0] rd_cell,
  output logic       current_player,
  output logic       move_ok,
  output logic       move_err,
  output logic       busy,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [6:0] tri_moves,
  output logic [6:0] cir_moves
);

  localparam int         NCELL  = BOARD_SIZE * BOARD_SIZE;
  localparam int         IW     = $clog2(NCELL);
  localparam logic [3:0] BS4    = 4'(BOARD_SIZE);
  localparam logic [3:0] KMAX   = 4'(WIN_LEN - 1);
  localparam logic [3:0] WL4    = 4'(WIN_LEN);
  localparam logic [7:0] NCELL8 = 8'(NCELL);

  typedef enum logic [1:0] {IDLE, SCAN, OVER} state_t;

  state_t             r_state;
  logic [1:0]         r_board [NCELL];
  logic [3:0]         r_px, r_py;
  logic [1:0]         r_dir;
  logic               r_neg;
  logic [3:0]         r_k;
  logic [3:0]         r_run;
  logic signed [4:0]  r_cx, r_cy;
  logic               r_player;
  logic               r_move_ok, r_move_err, r_busy, r_game_over;
  logic [1:0]         r_winner;
  logic [6:0]         r_tri, r_cir;

  function automatic logic signed [4:0] f_dx(input logic [1:0] d);
    return (d == 2'd1) ? 5'sd0 : 5'sd1;
  endfunction

  function automatic logic signed [4:0] f_dy(input logic [1:0] d);
    case (d)
      2'd0:    return 5'sd0;
      2'd3:    return -5'sd1;
      default: return 5'sd1;
    endcase
  endfunction

  function automatic logic [IW-1:0] f_idx(input logic [3:0] x, input logic [3:0] y);
    return IW'(int'(y) * BOARD_SIZE + int'(x));
  endfunction

  logic [1:0]        w_code;
  logic [IW-1:0]     w_in_idx, w_rd_idx, w_cand_idx;
  logic              w_cand_in, w_match;
  logic [3:0]        w_run_inc;
  logic signed [4:0] w_dx, w_dy, w_sdx, w_sdy, w_ndx, w_ndy, w_px5, w_py5;
  logic [7:0]        w_total;

  assign w_code     = r_player ? 2'b10 : 2'b01;
  assign w_in_idx   = f_idx(x_in, y_in);
  assign w_rd_idx   = f_idx(rd_x, rd_y);
  assign w_cand_idx = f_idx(r_cx[3:0], r_cy[3:0]);

  // Candidates only ever step one cell past the edge, so 5-bit signed never wraps.
  assign w_cand_in  = !r_cx[4] && !r_cy[4] && (r_cx[3:0] < BS4) && (r_cy[3:0] < BS4);
  assign w_match    = w_cand_in && (r_board[w_cand_idx] == w_code);
  assign w_run_inc  = r_run + 4'd1;

  assign w_dx  = f_dx(r_dir);
  assign w_dy  = f_dy(r_dir);
  assign w_sdx = r_neg ? -w_dx : w_dx;
  assign w_sdy = r_neg ? -w_dy : w_dy;
  assign w_ndx = f_dx(r_dir + 2'd1);
  assign w_ndy = f_dy(r_dir + 2'd1);
  assign w_px5 = $signed({1'b0, r_px});
  assign w_py5 = $signed({1'b0, r_py});

  assign w_total = 8'(r_tri) + 8'(r_cir);

  assign rd_cell        = (rd_x < BS4 && rd_y < BS4) ? r_board[w_rd_idx] : 2'b00;
  assign current_player = r_player;
  assign move_ok        = r_move_ok;
  assign move_err       = r_move_err;
  assign busy           = r_busy;
  assign game_over      = r_game_over;
  assign winner         = r_winner;
  assign tri_moves      = r_tri;
  assign cir_moves      = r_cir;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      for (int i = 0; i < NCELL; i++) r_board[i] <= 2'b00;
      r_px        <= '0;
      r_py        <= '0;
      r_dir       <= '0;
      r_neg       <= 1'b0;
      r_k         <= '0;
      r_run       <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_player    <= 1'b0;
      r_move_ok   <= 1'b0;
      r_move_err  <= 1'b0;
      r_busy      <= 1'b0;
      r_game_over <= 1'b0;
      r_winner    <= 2'b00;
      r_tri       <= '0;
      r_cir       <= '0;
    end else begin
      r_move_ok  <= 1'b0;
      r_move_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (coord_valid) begin
            if (x_in >= BS4 || y_in >= BS4 || r_board[w_in_idx] != 2'b00) begin
              r_move_err <= 1'b1;
            end else begin
              r_board[w_in_idx] <= w_code;
              if (r_player) r_cir <= r_cir + 7'd1;
              else          r_tri <= r_tri + 7'd1;
              r_move_ok <= 1'b1;
              r_busy    <= 1'b1;
              r_px      <= x_in;
              r_py      <= y_in;
              r_dir     <= 2'd0;
              r_neg     <= 1'b0;
              r_k       <= 4'd1;
              r_run     <= 4'd1;
              r_cx      <= $signed({1'b0, x_in}) + 5'sd1;
              r_cy      <= $signed({1'b0, y_in});
              r_state   <= SCAN;
            end
          end
        end

        SCAN: begin
          if (w_match && w_run_inc == WL4) begin
            r_winner    <= w_code;
            r_game_over <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= OVER;
          end else if (w_match && r_k != KMAX) begin
            r_k   <= r_k + 4'd1;
            r_run <= w_run_inc;
            r_cx  <= r_cx + w_sdx;
            r_cy  <= r_cy + w_sdy;
          end else if (!r_neg) begin
            // Run carries over into the negative phase of the same direction.
            r_neg <= 1'b1;
            r_k   <= 4'd1;
            if (w_match) r_run <= w_run_inc;
            r_cx  <= w_px5 - w_dx;
            r_cy  <= w_py5 - w_dy;
          end else if (r_dir != 2'd3) begin
            r_dir <= r_dir + 2'd1;
            r_neg <= 1'b0;
            r_k   <= 4'd1;
            r_run <= 4'd1;
            r_cx  <= w_px5 + w_ndx;
            r_cy  <= w_py5 + w_ndy;
          end else begin
            r_busy <= 1'b0;
`ifdef DRAW_DETECT_EN
            if (w_total == NCELL8) begin
              r_winner    <= 2'b11;
              r_game_over <= 1'b1;
              r_state     <= OVER;
            end else begin
              r_player <= ~r_player;
              r_state  <= IDLE;
            end
`else
            r_player <= ~r_player;
            r_state  <= IDLE;
`endif
          end
        end

        OVER: r_state <= OVER;

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_controller.sv
// Directed and random moves checked against a line-counting board model.
module tb_board_controller;

  localparam int BS = 10;
  localparam int WL = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] x_in = '0, y_in = '0, rd_x = '0, rd_y = '0;
  logic       coord_valid = 1'b0;
  logic [1:0] rd_cell, winner;
  logic       current_player, move_ok, move_err, busy, game_over;
  logic [6:0] tri_moves, cir_moves;

  int total = 0;
  int bad   = 0;

  int m_board [BS][BS];
  int m_player, m_tri, m_cir, m_over, m_winner;

  always #5 clk = ~clk;

  board_controller #(.BOARD_SIZE(BS), .WIN_LEN(WL)) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .coord_valid(coord_valid),
    .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell), .current_player(current_player),
    .move_ok(move_ok), .move_err(move_err), .busy(busy), .game_over(game_over),
    .winner(winner), .tri_moves(tri_moves), .cir_moves(cir_moves)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < BS; i++)
      for (int j = 0; j < BS; j++) m_board[i][j] = 0;
    m_player = 0; m_tri = 0; m_cir = 0; m_over = 0; m_winner = 0;
  endfunction

  // Length of the same-colour run starting next to (x,y) along (dx,dy), capped at WL-1.
  function automatic int run_len(int x, int y, int dx, int dy, int code);
    int n = 0;
    for (int k = 1; k < WL; k++) begin
      int cx = x + k * dx;
      int cy = y + k * dy;
      if (cx < 0 || cy < 0 || cx >= BS || cy >= BS) break;
      if (m_board[cx][cy] != code) break;
      n++;
    end
    return n;
  endfunction

  function automatic void model_scan(int x, int y, int code, output int win, output int cyc);
    int dxs [4] = '{1, 0, 1, 1};
    int dys [4] = '{0, 1, 1, -1};
    int p, n;
    win = 0;
    cyc = 0;
    for (int d = 0; d < 4; d++) begin
      p = run_len(x, y, dxs[d], dys[d], code);
      if (p == WL - 1) begin cyc += WL - 1; win = 1; return; end
      cyc += p + 1;
      n = run_len(x, y, -dxs[d], -dys[d], code);
      if (1 + p + n >= WL) begin cyc += WL - 1 - p; win = 1; return; end
      cyc += n + 1;
    end
  endfunction

  task automatic do_move(input int x, input int y);
    int exp_ok = 0, exp_err = 0, exp_cyc = 0, win = 0, cnt = 0, code;
    if (m_over == 0) begin
      if (x >= BS || y >= BS) exp_err = 1;
      else if (m_board[x][y] != 0) exp_err = 1;
      else begin
        exp_ok = 1;
        code = m_player ? 2 : 1;
        m_board[x][y] = code;
        if (m_player != 0) m_cir++; else m_tri++;
        model_scan(x, y, code, win, exp_cyc);
        if (win != 0) begin
          m_over = 1; m_winner = code;
        end else begin
`ifdef DRAW_DETECT_EN
          if (m_tri + m_cir == BS * BS) begin m_over = 1; m_winner = 3; end
          else m_player ^= 1;
`else
          m_player ^= 1;
`endif
        end
      end
    end
    @(negedge clk);
    x_in = x[3:0]; y_in = y[3:0]; rd_x = x[3:0]; rd_y = y[3:0];
    coord_valid = 1'b1;
    @(negedge clk);
    coord_valid = 1'b0;
    chk("move_ok", 32'(move_ok), exp_ok);
    chk("move_err", 32'(move_err), exp_err);
    chk("tri_moves", 32'(tri_moves), m_tri);
    chk("cir_moves", 32'(cir_moves), m_cir);
    if (x < BS && y < BS) chk("rd_cell", 32'(rd_cell), m_board[x][y]);
    while (busy === 1'b1 && cnt < 60) begin
      cnt++;
      @(negedge clk);
    end
    chk("busy_cycles", cnt, exp_cyc);
    chk("winner", 32'(winner), m_winner);
    chk("game_over", 32'(game_over), m_over);
    chk("player", 32'(current_player), m_player);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    int tq[$], cq[$];
    model_clear();

    // Reset state
    #12;
    rd_x = 4'd3; rd_y = 4'd4;
    chk("rst_cell", 32'(rd_cell), 0);
    chk("rst_player", 32'(current_player), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ok", 32'(move_ok), 0);
    chk("rst_err", 32'(move_err), 0);
    chk("rst_over", 32'(game_over), 0);
    chk("rst_winner", 32'(winner), 0);
    chk("rst_tri", 32'(tri_moves), 0);
    chk("rst_cir", 32'(cir_moves), 0);
    @(negedge clk);
    reset = 1'b0;

    // First move, occupied retry, out-of-range
    do_move(3, 4);
    do_move(3, 4);
    do_move(12, 0);
    do_move(0, 12);

    // Row win for triangle with circles interleaved in row 5
    do_move(0, 5); do_move(0, 0);
    do_move(1, 5); do_move(1, 0);
    do_move(2, 5); do_move(2, 0);
    do_move(7, 5); do_move(3, 0);
    chk("row_winner", 32'(winner), 1);
    do_move(5, 5);

    // Anti-diagonal win for circle
    do_reset();
    do_move(9, 9); do_move(3, 0);
    do_move(9, 7); do_move(2, 1);
    do_move(7, 9); do_move(1, 2);
    do_move(5, 9); do_move(0, 3);
    chk("diag_winner", 32'(winner), 2);

    // Reset in the middle of a scan
    do_reset();
    @(negedge clk);
    x_in = 4'd5; y_in = 4'd5; rd_x = 4'd5; rd_y = 4'd5; coord_valid = 1'b1;
    @(negedge clk);
    coord_valid = 1'b0;
    chk("mid_busy_pre", 32'(busy), 1);
    chk("mid_cell_pre", 32'(rd_cell), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_cell", 32'(rd_cell), 0);
    chk("mid_player", 32'(current_player), 0);
    chk("mid_tri", 32'(tri_moves), 0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    do_move(0, 0);

    // Random play
    do_reset();
    for (int i = 0; i < 60 && m_over == 0; i++)
      do_move(int'($urandom_range(0, 10)), int'($urandom_range(0, 10)));
    do_move(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));

    // Full board with no three-in-line: colour by (x + 2y) mod 4
    do_reset();
    for (int y = 0; y < BS; y++)
      for (int x = 0; x < BS; x++)
        if (((x + 2 * y) % 4) < 2) tq.push_back(x * 16 + y);
        else cq.push_back(x * 16 + y);
    for (int i = 0; i < 50; i++) begin
      do_move(tq[i] / 16, tq[i] % 16);
      do_move(cq[i] / 16, cq[i] % 16);
    end
    do_move(0, 0);
    for (int i = 0; i < 10; i++) begin
      int rx = int'($urandom_range(0, 9));
      int ry = int'($urandom_range(0, 9));
      rd_x = rx[3:0]; rd_y = ry[3:0];
      #1 chk("full_cell", 32'(rd_cell), m_board[rx][ry]);
    end
    rd_x = 4'd10; rd_y = 4'd3;
    #1 chk("oob_cell_x", 32'(rd_cell), 0);
    rd_x = 4'd3; rd_y = 4'd10;
    #1 chk("oob_cell_y", 32'(rd_cell), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
